// File: rtl/iter_divider_if.sv
// Handshake bundle for iter_divider.
//   Operand side : divisor and dividend streams (tdata/tvalid/tready each), plus
//                  div_signed (sampled with the operands) and div_cancel (abort).
//   Result side  : m_axis_dout_* stream, tdata = {quotient, remainder}.
// The slave modport is the divider, the master modport is whoever drives it.
interface iter_divider_if;
  logic [31:0] s_axis_divisor_tdata;
  logic        s_axis_divisor_tvalid;
  logic        s_axis_divisor_tready;
  logic [31:0] s_axis_dividend_tdata;
  logic        s_axis_dividend_tvalid;
  logic        s_axis_dividend_tready;
  logic        div_signed;
  logic        div_cancel;
  logic [63:0] m_axis_dout_tdata;
  logic        m_axis_dout_tvalid;
  logic        m_axis_dout_tready;

  modport slave (
    input  s_axis_divisor_tdata,
    input  s_axis_divisor_tvalid,
    output s_axis_divisor_tready,
    input  s_axis_dividend_tdata,
    input  s_axis_dividend_tvalid,
    output s_axis_dividend_tready,
    input  div_signed,
    input  div_cancel,
    output m_axis_dout_tdata,
    output m_axis_dout_tvalid,
    input  m_axis_dout_tready
  );

  modport master (
    output s_axis_divisor_tdata,
    output s_axis_divisor_tvalid,
    input  s_axis_divisor_tready,
    output s_axis_dividend_tdata,
    output s_axis_dividend_tvalid,
    input  s_axis_dividend_tready,
    output div_signed,
    output div_cancel,
    input  m_axis_dout_tdata,
    input  m_axis_dout_tvalid,
    output m_axis_dout_tready
  );
endinterface

// File: rtl/iter_divider.sv
// Iterative 32/32 restoring divider, signed or unsigned, one quotient bit per cycle.
//   clk    : rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : iter_divider_if.slave -- joint divisor/dividend transfer, div_signed,
//            div_cancel, result stream {quotient[63:32], remainder[31:0]}.
// Divide by zero returns quotient 0xFFFFFFFF and the original dividend as remainder.
module iter_divider (
  input logic           clk,
  input logic           resetn,
  iter_divider_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [63:0] rem_q;        // {partial remainder, dividend bits / quotient bits}
  logic [31:0] divisor_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        dbz_q;
  logic [63:0] dout_q;
  logic        tvalid_q, tvalid_d;

  logic        xfer;
  logic        hshake;
  logic        dvd_neg, dvs_neg;
  logic [31:0] dvd_abs, dvs_abs;
  logic [32:0] trial;
  logic [63:0] rem_next;
  logic [31:0] q_fix, r_fix;

  // Both operands move together; cancel blocks the transfer.
  assign xfer = resetn & (state_q == StIdle) & bus.s_axis_divisor_tvalid &
                bus.s_axis_dividend_tvalid & ~bus.div_cancel;
  assign hshake = tvalid_q & bus.m_axis_dout_tready;

  assign bus.s_axis_divisor_tready  = xfer;
  assign bus.s_axis_dividend_tready = xfer;
  assign bus.m_axis_dout_tvalid     = tvalid_q;
  assign bus.m_axis_dout_tdata      = dout_q;

  // Operand magnitudes; in unsigned mode the top bit is just a data bit.
  assign dvd_neg = bus.div_signed & bus.s_axis_dividend_tdata[31];
  assign dvs_neg = bus.div_signed & bus.s_axis_divisor_tdata[31];
  assign dvd_abs = dvd_neg ? (32'd0 - bus.s_axis_dividend_tdata) : bus.s_axis_dividend_tdata;
  assign dvs_abs = dvs_neg ? (32'd0 - bus.s_axis_divisor_tdata) : bus.s_axis_divisor_tdata;

  // One restoring step: the shifted partial remainder needs 33 bits for the compare.
  assign trial    = rem_q[63:31] - {1'b0, divisor_q};
  assign rem_next = trial[32] ? {rem_q[62:0], 1'b0}
                              : {trial[31:0], rem_q[30:0], 1'b1};

  // With a zero divisor every trial succeeds, leaving |dividend| as the remainder;
  // re-applying the dividend sign restores the original dividend.
  assign q_fix = dbz_q   ? 32'hFFFF_FFFF :
                 q_neg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
  assign r_fix = r_neg_q ? (32'd0 - rem_q[63:32]) : rem_q[63:32];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tvalid_d = 1'b0;
    unique case (state_q)
      StIdle: if (xfer) state_d = StCalc;
      StCalc: if (cnt_q == 5'd31) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: begin
        // tvalid is registered off DONE, so the first DONE cycle only aligns it.
        tvalid_d = ~hshake;
        if (hshake) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (bus.div_cancel) begin
      state_d  = StIdle;
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q     <= 5'd0;
      rem_q     <= 64'd0;
      divisor_q <= 32'd0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      dout_q    <= 64'd0;
      tvalid_q  <= 1'b0;
    end else begin
      tvalid_q <= tvalid_d;
      if (xfer) begin
        cnt_q     <= 5'd0;
        rem_q     <= {32'd0, dvd_abs};
        divisor_q <= dvs_abs;
        q_neg_q   <= dvd_neg ^ dvs_neg;
        r_neg_q   <= dvd_neg;
        dbz_q     <= (bus.s_axis_divisor_tdata == 32'd0);
      end else if (state_q == StCalc) begin
        cnt_q <= cnt_q + 5'd1;
        rem_q <= rem_next;
      end
      if (state_q == StFix && !bus.div_cancel) begin
        dout_q <= {q_fix, r_fix};
      end
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: hand-computed results, latency, handshake
// holding, cancel and mid-operation reset.
module tb_iter_divider;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  iter_divider_if bus ();

  iter_divider dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; leaves the bench just after transfer edge E0.
  task automatic start_op(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                          input logic sgn);
    bus.s_axis_dividend_tdata  = dvd;
    bus.s_axis_divisor_tdata   = dvs;
    bus.div_signed             = sgn;
    bus.s_axis_dividend_tvalid = 1'b1;
    bus.s_axis_divisor_tvalid  = 1'b1;
    @(negedge clk);
    check({tag, "_tready"}, {62'd0, bus.s_axis_dividend_tready, bus.s_axis_divisor_tready},
          64'd3);
    @(posedge clk);
    #1;
    bus.s_axis_dividend_tvalid = 1'b0;
    bus.s_axis_divisor_tvalid  = 1'b0;
    bus.div_signed             = 1'b0;
  endtask

  // Waits for tvalid (bounded), checks latency and data, optionally stalls the
  // consumer for hold cycles, then completes the handshake.
  task automatic wait_result(input string tag, input logic [63:0] exp, input int hold);
    int          n;
    logic [63:0] first;
    logic        bad_hold;
    n = 0;
    while (bus.m_axis_dout_tvalid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd34);
    check({tag, "_data"}, bus.m_axis_dout_tdata, exp);
    first    = bus.m_axis_dout_tdata;
    bad_hold = 1'b0;
    if (hold > 0) begin
      // Operands offered while DONE must not be taken.
      bus.s_axis_dividend_tvalid = 1'b1;
      bus.s_axis_divisor_tvalid  = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (bus.s_axis_dividend_tready || bus.s_axis_divisor_tready) bad_hold = 1'b1;
        @(posedge clk);
        #1;
        if (bus.m_axis_dout_tvalid !== 1'b1 || bus.m_axis_dout_tdata !== first) bad_hold = 1'b1;
      end
      bus.s_axis_dividend_tvalid = 1'b0;
      bus.s_axis_divisor_tvalid  = 1'b0;
      check({tag, "_hold"}, {63'd0, bad_hold}, 64'd0);
    end
    bus.m_axis_dout_tready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_axis_dout_tready = 1'b0;
    check({tag, "_tvalid_drop"}, {63'd0, bus.m_axis_dout_tvalid}, 64'd0);
  endtask

  // Watches tvalid for a number of cycles; it must stay low.
  task automatic expect_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.m_axis_dout_tvalid !== 1'b0) seen = 1'b1;
    end
    check(tag, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    logic bad;
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    bus.s_axis_divisor_tdata   = 32'd3;
    bus.s_axis_dividend_tdata  = 32'd9;
    bus.s_axis_divisor_tvalid  = 1'b1;
    bus.s_axis_dividend_tvalid = 1'b1;
    bus.div_signed             = 1'b0;
    bus.div_cancel             = 1'b0;
    bus.m_axis_dout_tready     = 1'b0;

    // Reset state, with operands offered throughout.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", {62'd0, bus.s_axis_dividend_tready, bus.s_axis_divisor_tready}, 64'd0);
    check("rst_tvalid", {63'd0, bus.m_axis_dout_tvalid}, 64'd0);
    check("rst_tdata", bus.m_axis_dout_tdata, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // First transfer possible right after reset release.
    start_op("u100_7", 32'd100, 32'd7, 1'b0);
    wait_result("u100_7", 64'h0000000E_00000002, 0);

    start_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_result("s_m7_2", 64'hFFFFFFFD_FFFFFFFF, 0);

    start_op("u_ffff_10", 32'hFFFF_FFFF, 32'h10, 1'b0);
    wait_result("u_ffff_10", 64'h0FFFFFFF_0000000F, 0);

    start_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_result("s_7_m2", 64'hFFFFFFFD_00000001, 0);

    start_op("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1);
    wait_result("s_m100_7", 64'hFFFFFFF2_FFFFFFFE, 0);

    start_op("u_5_0", 32'd5, 32'd0, 1'b0);
    wait_result("u_5_0", 64'hFFFFFFFF_00000005, 0);

    start_op("s_5_0", 32'd5, 32'd0, 1'b1);
    wait_result("s_5_0", 64'hFFFFFFFF_00000005, 0);

    start_op("s_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1);
    wait_result("s_m5_0", 64'hFFFFFFFF_FFFFFFFB, 0);

    start_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_result("s_ovf", 64'h80000000_00000000, 0);

    // Divisor alone must not transfer.
    bus.s_axis_divisor_tdata  = 32'd5;
    bus.s_axis_dividend_tdata = 32'd50;
    bus.s_axis_divisor_tvalid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.s_axis_dividend_tready || bus.s_axis_divisor_tready) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    check("lone_divisor", {63'd0, bad}, 64'd0);
    start_op("u50_5", 32'd50, 32'd5, 1'b0);
    // Stalled consumer, then a transfer in the very next cycle.
    wait_result("u50_5", 64'h0000000A_00000000, 5);
    start_op("u81_9", 32'd81, 32'd9, 1'b0);
    wait_result("u81_9", 64'h00000009_00000000, 0);

    // Cancel blocks a same-cycle transfer.
    bus.s_axis_divisor_tvalid  = 1'b1;
    bus.s_axis_dividend_tvalid = 1'b1;
    bus.div_cancel             = 1'b1;
    @(negedge clk);
    check("cancel_blocks", {62'd0, bus.s_axis_dividend_tready, bus.s_axis_divisor_tready},
          64'd0);
    @(posedge clk);
    #1;
    bus.s_axis_divisor_tvalid  = 1'b0;
    bus.s_axis_dividend_tvalid = 1'b0;
    bus.div_cancel             = 1'b0;

    // Cancel pulse 10 cycles into CALC.
    start_op("cancel", 32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.div_cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.div_cancel = 1'b0;
    expect_quiet("cancel_quiet", 50);
    start_op("u9_3", 32'd9, 32'd3, 1'b0);
    wait_result("u9_3", 64'h00000003_00000000, 0);

    // Reset mid-CALC aborts the operation.
    start_op("rst_mid", 32'd1000, 32'd3, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check("rst_mid_tvalid", {63'd0, bus.m_axis_dout_tvalid}, 64'd0);
    expect_quiet("rst_mid_quiet", 40);
    start_op("u9_3b", 32'd9, 32'd3, 1'b0);
    wait_result("u9_3b", 64'h00000003_00000000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
